// File: rtl/tdp_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : tdp_pkg
//  Description : Shared types for the tdp burst reader: request/command/output
//                word layouts, FSM state encoding and credit-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package tdp_pkg;

  // Default field widths of the tdp port these structs describe
  localparam int TDP_W_DATA = 16;
  localparam int TDP_W_ADDR = 16;
  localparam int TDP_W_LEN  = 16;

  // Memory request word; field order is shared with the tdp port
  typedef struct packed {
    logic                  ctrl;
    logic [TDP_W_DATA-1:0] data;
    logic [TDP_W_ADDR-1:0] addr;
  } req_t;

  // Burst command word
  typedef struct packed {
    logic [TDP_W_LEN-1:0]  len;
    logic [TDP_W_ADDR-1:0] addr;
  } cmd_t;

  // Output stream word
  typedef struct packed {
    logic                  eot;
    logic [TDP_W_DATA-1:0] data;
  } dout_t;

  // Reader FSM state encoding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Credit counter must be able to hold the value MAX_OUTST itself
  function automatic int credit_width(input int max_outst);
    return $clog2(max_outst + 1);
  endfunction

endpackage : tdp_pkg
`default_nettype wire

// File: rtl/tdp_reader_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tdp_reader_fifo
//  Description : Synchronous FIFO (power-of-two DEPTH) with full/empty flags
//                and occupancy count. Pointers carry one extra wrap bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tdp_reader_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // A push into a full FIFO is accepted only when a pop frees a slot the same cycle
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count    = wr_ptr - rd_ptr;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // Storage array; contents need no reset because the flags gate every read
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  // Read/write pointers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule : tdp_reader_fifo
`default_nettype wire

// File: rtl/tdp_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tdp_reader
//  Description : Burst read initiator for one tdp RAM port. Takes {len, addr},
//                issues len read requests under credit control, buffers the
//                returned words and re-emits them with eot on the last word.
//                Optional macro TDP_READER_WRAP_EN: addresses wrap from
//                DEPTH-1 to 0 (ring-buffer read) instead of at 2^W_ADDR.
//  Revision    : 1.0 - initial release
// ============================================================================
module tdp_reader
  import tdp_pkg::*;
#(
  parameter int W_DATA    = 16,
  parameter int W_ADDR    = 16,
  parameter int W_LEN     = 16,
  parameter int MAX_OUTST = 4,
  parameter int DEPTH     = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  // command: {len, addr}
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [W_LEN+W_ADDR-1:0]    cmd_data,
  // memory request: {ctrl, data, addr}
  output logic                       req_valid,
  input  logic                       req_ready,
  output logic [W_DATA+W_ADDR:0]     req_data,
  // read data from the memory port
  input  logic                       rdata_valid,
  output logic                       rdata_ready,
  input  logic [W_DATA-1:0]          rdata_data,
  // output stream: {eot, data}
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic [W_DATA:0]            dout_data
);

  localparam int CRED_W = credit_width(MAX_OUTST);
  localparam int CNT_W  = $clog2(MAX_OUTST) + 1;

`ifdef TDP_READER_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  state_t              state;
  state_t              state_nxt;
  logic [W_ADDR-1:0]   cur_addr;
  logic [W_ADDR-1:0]   next_addr;
  logic [W_LEN-1:0]    rem_req;
  logic [W_LEN-1:0]    rem_out;
  logic [CRED_W-1:0]   credits;
  logic [W_LEN-1:0]    cmd_len;
  logic [W_ADDR-1:0]   cmd_addr;
  logic                idle_ready;
  logic                issue_valid;
  logic                cmd_xfer;
  logic                cmd_start;
  logic                req_xfer;
  logic                dout_xfer;
  logic                fifo_full;
  logic                fifo_empty;
  logic [W_DATA-1:0]   fifo_head;
  logic [CNT_W-1:0]    fifo_count;

  assign cmd_len  = cmd_data[W_LEN+W_ADDR-1 -: W_LEN];
  assign cmd_addr = cmd_data[W_ADDR-1:0];

  // Ready outputs are gated by reset so they drop the instant rst falls
  assign cmd_ready   = idle_ready && rst;
  assign rdata_ready = !fifo_full && rst;
  assign req_valid   = issue_valid;
  assign req_data    = {1'b0, {W_DATA{1'b0}}, cur_addr};
  assign dout_valid  = !fifo_empty;
  assign dout_data   = {(rem_out == W_LEN'(1)), fifo_head};

  assign cmd_xfer  = cmd_valid && cmd_ready;
  assign cmd_start = cmd_xfer && (cmd_len != '0);
  assign req_xfer  = req_valid && req_ready;
  assign dout_xfer = dout_valid && dout_ready;

  // Address increment; a command addr beyond DEPTH-1 simply counts up to 2^W_ADDR
  assign next_addr = (WRAP_EN && (cur_addr == W_ADDR'(DEPTH - 1))) ? '0
                                                                 : cur_addr + W_ADDR'(1);

  // FSM next-state and handshake outputs
  always_comb begin
    state_nxt   = state;
    idle_ready  = 1'b0;
    issue_valid = 1'b0;
    case (state)
      IDLE: begin
        idle_ready = 1'b1;
        if (cmd_start) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        issue_valid = (credits < CRED_W'(MAX_OUTST));
        if (req_xfer && (rem_req == W_LEN'(1))) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (dout_xfer && (rem_out == W_LEN'(1))) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Request address and remaining-request counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_addr <= '0;
      rem_req  <= '0;
    end else if (cmd_start) begin
      cur_addr <= cmd_addr;
      rem_req  <= cmd_len;
    end else if (req_xfer) begin
      cur_addr <= next_addr;
      rem_req  <= rem_req - W_LEN'(1);
    end
  end

  // Remaining-output counter; drives eot on the final word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_out <= '0;
    end else if (cmd_start) begin
      rem_out <= cmd_len;
    end else if (dout_xfer) begin
      rem_out <= rem_out - W_LEN'(1);
    end
  end

  // Credits: words issued but not yet emitted; bounds FIFO plus in-flight reads
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credits <= '0;
    end else begin
      case ({req_xfer, dout_xfer})
        2'b10:   credits <= credits + CRED_W'(1);
        2'b01:   credits <= credits - CRED_W'(1);
        default: credits <= credits;
      endcase
    end
  end

  tdp_reader_fifo #(
    .W     (W_DATA),
    .DEPTH (MAX_OUTST)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rdata_valid && rdata_ready),
    .push_data (rdata_data),
    .pop       (dout_xfer),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Returned data is legal only while some issued read is not yet in the FIFO
  a_rdata_has_credit : assert property (
    @(posedge clk) disable iff (!rst)
    rdata_valid |-> (32'(credits) > 32'(fifo_count))
  );

endmodule : tdp_reader
`default_nettype wire

// File: doc/tdp_reader.md
Name: tdp_reader

Overview:
- Burst read initiator for one port of the dual-port RAM block.
- Accepts a command {len, addr} and issues `len` consecutive read requests on a dti request interface.
- Collects the returned words in a small credit-protected FIFO and re-emits them as a dti stream, with eot set on the last word.
- Sits between a DMA/control engine and a tdp request/dout port pair.

Parameters:
- W_DATA, 16, memory word width.
- W_ADDR, 16, memory address width.
- W_LEN, 16, burst length field width (word count).
- MAX_OUTST, 4, max words issued but not yet output; also the FIFO depth; power of two ≥ 2.
- DEPTH, 1024, memory depth; used only by the optional feature.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  reset; asynchronous, active-low (assert 0 clears all state immediately; deassertion is synchronised externally).
- cmd  dti.consumer  W_LEN+W_ADDR  command; data = {len[MSB], addr[LSB]}.
- req  dti.producer  1+W_DATA+W_ADDR  memory request; data = {ctrl[MSB], data, addr[LSB]}.
- rdata  dti.consumer  W_DATA  read data returned by the memory port.
- dout  dti.producer  1+W_DATA  output stream; data = {eot[MSB], data[LSB]}.

Behaviour:
- Handshake (all dti ports): transfer when valid && ready. A producer holds valid and data stable until the transfer.
- FSM states:
  - IDLE: cmd.ready=1.
    - On cmd transfer with len≠0: latch addr→cur_addr and len→rem_req and len→rem_out; go ISSUE.
    - len=0: consume the command, stay IDLE, emit nothing.
  - ISSUE: cmd.ready=0.
    - req.valid=1 when credits < MAX_OUTST.
    - req.data = {1'b0, W_DATA'0, cur_addr}; ctrl is always 0 (read only).
    - On req transfer: cur_addr+1 (wraps modulo 2^W_ADDR), rem_req−1, credits+1.
    - When the last request transfers: go DRAIN.
  - DRAIN: req.valid=0. When the last dout word transfers: go IDLE.
- Timing:
  - req.valid rises at the earliest one cycle after the cmd transfer.
  - A new cmd can be accepted the cycle after the last dout transfer.
- Credits:
  - Counter of width clog2(MAX_OUTST+1).
  - +1 per req transfer, −1 per dout transfer; both in the same cycle → unchanged.
  - Guarantees FIFO occupancy + in-flight reads ≤ MAX_OUTST, so the FIFO never overflows.
- FIFO:
  - Depth MAX_OUTST. rdata.ready = !full (full is never reached under correct memory behaviour).
  - Simultaneous push and pop on a full or empty FIFO is legal.
- Output:
  - dout.valid = !fifo_empty; dout.data = {eot, head}.
  - eot = (rem_out == 1).
  - rem_out −1 per dout transfer.
- Full throughput: one word per cycle sustained when dout.ready=1 and MAX_OUTST ≥ 2.
- Reset values (rst=0), effective immediately:
  - cmd.ready=0; req.valid=0; dout.valid=0; rdata.ready=0.
  - FSM=IDLE; all counters 0; FIFO empty.
  - Reset during a burst discards the remaining data. The system resets the tdp port together with this block.
- rdata arriving with no outstanding credit is a protocol error. Behaviour is undefined; the assertion below checks it.

Optional Feature:
- Macro: TDP_READER_WRAP_EN.
- Defined: cur_addr wraps from DEPTH−1 to 0, giving a ring-buffer read. A command addr ≥ DEPTH is taken modulo nothing and used as given until the first wrap check.
- Undefined: wrap only at 2^W_ADDR; DEPTH is unused.

Decomposition:
- Package tdp_pkg:
  - req struct typedef {ctrl, data, addr}, shared with the tdp port (field order fixed).
  - cmd struct typedef {len, addr}.
  - dout struct typedef {eot, data}.
  - Function for clog2-based credit width.
  - localparams for the FSM state enum (IDLE, ISSUE, DRAIN).
- Sub-module: tdp_reader_fifo (parameters W, DEPTH). Synchronous FIFO with async active-low reset and full/empty flags.
- Top file: FSM, counters, address generation.

Test Plan:
- cmd {len=4, addr=0x10}, memory preloaded mem[a]=a+0x100, dout.ready=1 → dout words 0x110,0x111,0x112,0x113; eot only on 0x113; 4 reqs with ctrl=0.
- Same cmd, dout.ready held 0 → exactly MAX_OUTST=4 reqs issued then req.valid=0. Release dout.ready → remaining words follow; credits never exceed 4.
- cmd len=0 → cmd consumed in 1 cycle; no req, no dout; next cmd accepted next cycle.
- cmd {len=3, addr=0xFFFF}, wrap macro off → addresses 0xFFFF,0x0000,0x0001.
- With TDP_READER_WRAP_EN, DEPTH=1024, cmd {len=3, addr=1023} → addresses 1023,0,1.
- Assert rst=0 mid-burst (after 2 of 8 words) → all valids drop in the same cycle. After release, a new cmd {len=2, addr=5} yields mem[5], mem[6] with eot on mem[6].
